// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage (master) and imem (slave).
interface fetch_stage_if #(
  parameter int DPW = 32
);
  logic           imem_req;
  logic [DPW-1:0] imem_addr;
  logic           imem_gnt;
  logic           imem_rvalid;
  logic [DPW-1:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_gnt, imem_rvalid, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_gnt, imem_rvalid, imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// RV32I fetch: owns PC, req/gnt/rvalid imem port, 2-entry fetch queue, IF/ID register; FETCH_PERF_EN adds a bubble counter.
// gnt -> instrD valid two edges later at best; in-flight + queued capped at 2, stallD holds IF/ID and stops pops.
module fetch_stage #(
  parameter int             DPW       = 32,
  parameter logic [DPW-1:0] RESET_PC  = '0,
  parameter logic [DPW-1:0] NOP_INSTR = DPW'(32'h0000_0013)
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              stallD,
  input  logic              flushD,
  input  logic              branch_taken,
  input  logic [DPW-1:0]    branch_target,
  fetch_stage_if.master     imem,
  output logic [DPW-1:0]    instrD,
  output logic [DPW-1:0]    PCD,
  output logic              validD,
  output logic [31:0]       perf_bubble_cnt
);

  logic [DPW-1:0] pc_f;
  logic [1:0]     out_cnt;
  logic [1:0]     disc_cnt;

  logic [DPW-1:0] tag_pc [2];
  logic           tag_wp, tag_rp;

  logic [DPW-1:0] q_pc    [2];
  logic [DPW-1:0] q_instr [2];
  logic           q_wp, q_rp;
  logic [1:0]     q_cnt;

  logic [2:0] used;
  logic       grant, drop, accept, push, pop, q_empty;

  // Responses still owed to discard hold their credit until they drain, so the tag FIFO never overflows.
  assign used    = {1'b0, out_cnt} + {1'b0, disc_cnt} + {1'b0, q_cnt};
  assign q_empty = (q_cnt == 2'd0);

  assign imem.imem_req  = !arst && (used < 3'd2) && !branch_taken;
  assign imem.imem_addr = pc_f;

  assign grant  = imem.imem_req && imem.imem_gnt;
  assign drop   = imem.imem_rvalid && (disc_cnt != 2'd0);
  assign accept = imem.imem_rvalid && (disc_cnt == 2'd0);
  assign push   = accept && !branch_taken;
  assign pop    = !branch_taken && !flushD && !stallD && !q_empty;

  always_ff @(posedge clk) begin
    if (grant) tag_pc[tag_wp] <= pc_f;
    if (push) begin
      q_pc[q_wp]    <= tag_pc[tag_rp];
      q_instr[q_wp] <= imem.imem_rdata;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      pc_f     <= RESET_PC;
      out_cnt  <= 2'd0;
      disc_cnt <= 2'd0;
      tag_wp   <= 1'b0;
      tag_rp   <= 1'b0;
      q_wp     <= 1'b0;
      q_rp     <= 1'b0;
      q_cnt    <= 2'd0;
      instrD   <= NOP_INSTR;
      PCD      <= '0;
      validD   <= 1'b0;
    end else begin
      if (grant)             tag_wp <= ~tag_wp;
      if (imem.imem_rvalid)  tag_rp <= ~tag_rp;

      if (branch_taken) begin
        pc_f     <= branch_target & ~DPW'(3);
        out_cnt  <= 2'd0;
        disc_cnt <= disc_cnt - {1'b0, drop} + out_cnt - {1'b0, accept};
        q_wp     <= 1'b0;
        q_rp     <= 1'b0;
        q_cnt    <= 2'd0;
      end else begin
        if (grant) pc_f <= pc_f + DPW'(4);
        out_cnt  <= out_cnt + {1'b0, grant} - {1'b0, accept};
        disc_cnt <= disc_cnt - {1'b0, drop};
        if (push) q_wp <= ~q_wp;
        if (pop)  q_rp <= ~q_rp;
        q_cnt    <= q_cnt + {1'b0, push} - {1'b0, pop};
      end

      if (flushD || branch_taken) begin
        instrD <= NOP_INSTR;
        PCD    <= '0;
        validD <= 1'b0;
      end else if (!stallD) begin
        if (!q_empty) begin
          instrD <= q_instr[q_rp];
          PCD    <= q_pc[q_rp];
          validD <= 1'b1;
        end else begin
          instrD <= NOP_INSTR;
          PCD    <= '0;
          validD <= 1'b0;
        end
      end
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      perf_bubble_cnt <= '0;
    end else if (!flushD && !branch_taken && !stallD && q_empty && (perf_bubble_cnt != '1)) begin
      perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
    end
  end
`else
  assign perf_bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: cycle table for streaming/stall/flush, hand sequences for redirect, wrap and perf counter.
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic        stallD = 1'b0, flushD = 1'b0, branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic [31:0] instrD, PCD, perf;
  logic        validD;
  logic        gnt_en = 1'b1;
  int          lat = 1;
  int          cyc = 0;
  int          checks = 0, failures = 0;

  fetch_stage_if #(.DPW(32)) bus ();

  fetch_stage #(.DPW(32), .RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
    .clk(clk), .arst(arst), .stallD(stallD), .flushD(flushD),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem(bus.master), .instrD(instrD), .PCD(PCD), .validD(validD),
    .perf_bubble_cnt(perf)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Memory model: in-order responses, each presented lat cycles after its grant edge.
  typedef struct { logic [31:0] addr; int rdy; } mreq_t;
  mreq_t pend[$];

  assign bus.imem_gnt = gnt_en;
  initial begin
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!arst && bus.imem_req && bus.imem_gnt) pend.push_back('{bus.imem_addr, cyc + lat});
    if (!arst && bus.imem_rvalid && pend.size() == 0) begin
      failures++;
      $display("FAIL protocol: rvalid with no outstanding request at cycle %0d", cyc);
    end
  end

  always @(posedge clk) begin
    #1;
    if (arst) begin
      pend.delete();
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = '0;
    end else begin
      if (bus.imem_rvalid) void'(pend.pop_front());
      bus.imem_rvalid = (pend.size() > 0) && (pend[0].rdy <= cyc);
      bus.imem_rdata  = bus.imem_rvalid ? mem_word(pend[0].addr) : '0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_valid(input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (validD) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: validD never rose, got 0 expected 1 within 40 cycles", name);
    end
  endtask

  task automatic do_reset();
    arst = 1'b1;
    repeat (2) @(posedge clk);
    #1 arst = 1'b0;
  endtask

  typedef struct {
    logic        stall;
    logic        flush;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pcd;
  } vec_t;
  vec_t tbl[19];

  logic [31:0] p0, p1;

  initial begin
    // One row per cycle after reset release, latency 1, gnt always high.
    tbl[0]  = '{1'b0, 1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 32'h04, 1'b0, 32'h00};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 32'h08, 1'b0, 32'h00};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 32'h08, 1'b1, 32'h00};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 32'h0C, 1'b1, 32'h04};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 32'h10, 1'b0, 32'h00};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 32'h08};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 32'h14, 1'b1, 32'h0C};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 32'h18, 1'b0, 32'h00};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 32'h18, 1'b1, 32'h10};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 32'h1C, 1'b1, 32'h10};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 32'h1C, 1'b1, 32'h10};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 32'h1C, 1'b1, 32'h10};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 32'h1C, 1'b1, 32'h14};
    tbl[14] = '{1'b0, 1'b0, 1'b1, 32'h20, 1'b1, 32'h18};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 32'h24, 1'b0, 32'h00};
    tbl[16] = '{1'b0, 1'b1, 1'b1, 32'h24, 1'b1, 32'h1C};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 32'h28, 1'b0, 32'h00};
    tbl[18] = '{1'b0, 1'b0, 1'b1, 32'h28, 1'b1, 32'h20};

    do_reset();
    for (int k = 0; k < 19; k++) begin
      stallD = tbl[k].stall;
      flushD = tbl[k].flush;
      @(negedge clk);
      if (k == 0) chk("perf_reset", perf, 32'h0);
      chk($sformatf("c%0d_req", k),    {31'b0, bus.imem_req}, {31'b0, tbl[k].req});
      chk($sformatf("c%0d_addr", k),   bus.imem_addr, tbl[k].addr);
      chk($sformatf("c%0d_validD", k), {31'b0, validD}, {31'b0, tbl[k].valid});
      chk($sformatf("c%0d_PCD", k),    PCD, tbl[k].pcd);
      chk($sformatf("c%0d_instrD", k), instrD, tbl[k].valid ? mem_word(tbl[k].pcd) : NOP);
      @(posedge clk);
      #1;
    end
    stallD = 1'b0;
    flushD = 1'b0;

    // Asynchronous reset in the middle of streaming.
    arst = 1'b1;
    #1;
    chk("rst_req", {31'b0, bus.imem_req}, 32'h0);
    chk("rst_addr", bus.imem_addr, 32'h0);
    chk("rst_validD", {31'b0, validD}, 32'h0);
    chk("rst_instrD", instrD, NOP);
    chk("rst_PCD", PCD, 32'h0);

    // Redirect with two requests in flight at latency 3.
    lat = 3;
    do_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0103;
    @(negedge clk);
    chk("br_req_blocked", {31'b0, bus.imem_req}, 32'h0);
    @(posedge clk); #1;
    branch_taken = 1'b0;
    @(negedge clk);
    chk("br_addr", bus.imem_addr, 32'h0000_0100);
    chk("br_bubble", {31'b0, validD}, 32'h0);
    wait_valid("br_first_valid");
    chk("br_first_PCD", PCD, 32'h0000_0100);
    chk("br_first_instr", instrD, mem_word(32'h0000_0100));
    wait_valid("br_second_valid");
    chk("br_second_PCD", PCD, 32'h0000_0104);

    // PC wrap-around, then idle for the bubble counter.
    arst   = 1'b1;
    lat    = 1;
    gnt_en = 1'b0;
    do_reset();
    branch_taken  = 1'b1;
    branch_target = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    branch_taken = 1'b0;
    gnt_en       = 1'b1;
    @(negedge clk);
    chk("wrap_addr_pre", bus.imem_addr, 32'hFFFF_FFFC);
    chk("wrap_req", {31'b0, bus.imem_req}, 32'h1);
    @(posedge clk); #1;
    gnt_en = 1'b0;
    @(negedge clk);
    chk("wrap_addr_post", bus.imem_addr, 32'h0000_0000);
    wait_valid("wrap_valid");
    chk("wrap_PCD", PCD, 32'hFFFF_FFFC);
    chk("wrap_instr", instrD, mem_word(32'hFFFF_FFFC));

    p0 = perf;
    repeat (5) @(negedge clk);
    p1 = perf;
    chk("idle_validD", {31'b0, validD}, 32'h0);
`ifdef FETCH_PERF_EN
    chk("perf_delta", p1 - p0, 32'd5);
`else
    chk("perf_off_a", p0, 32'h0);
    chk("perf_off_b", p1, 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage of the 5-stage RV32I pipeline, directly upstream of the decode/register-read stage.
- Owns the PC and issues requests to instruction memory over a req/gnt/rvalid interface with variable latency.
- Buffers responses in a 2-entry fetch queue and drives the IF/ID pipeline register (instrD, PCD, validD).
- Handles stall, flush and branch redirect, including discarding in-flight wrong-path responses.

Parameters:
DPW, 32, datapath/instruction width (matches rv32i_pkg::DPW)
RESET_PC, 32'h0000_0000, PC value after reset
NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0)

Ports:
clk  input  1  clock, rising edge
arst  input  1  asynchronous reset, active-high
stallD  input  1  hold IF/ID register contents
flushD  input  1  clear IF/ID register to a bubble
branch_taken  input  1  redirect fetch this cycle
branch_target  input  DPW  redirect PC
imem_req  output  1  request valid
imem_addr  output  DPW  request byte address
imem_gnt  input  1  request accepted this cycle
imem_rvalid  input  1  response valid (in order, >=1 cycle after gnt)
imem_rdata  input  DPW  response instruction
instrD  output  DPW  instruction to decode
PCD  output  DPW  PC of instrD
validD  output  1  instrD is a real instruction
perf_bubble_cnt  output  32  bubble counter (see Optional Feature)

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset values: pcF=RESET_PC, outstanding=0, discard=0, queue empty, imem_req=0, imem_addr=RESET_PC, instrD=NOP_INSTR, PCD=0, validD=0, perf_bubble_cnt=0.
- Credit rule: imem_req=1 iff (outstanding + queue_count) < 2 and !branch_taken.
- imem_addr=pcF, combinational from the register.
- On imem_req && imem_gnt: pcF += 4 (mod 2^DPW, wraps silently); outstanding++; the request PC is pushed into an internal 2-entry PC tag FIFO.
- On imem_rvalid:
  - If discard>0: drop the response, discard--, pop the tag.
  - Else: push {tag PC, imem_rdata} into the fetch queue; outstanding--.
- Simultaneous gnt and rvalid in the same cycle: outstanding stays unchanged; the tag FIFO is pushed and popped.
- Queue never overflows by construction of the credit rule. A response arriving with no outstanding request is a protocol error; the bench asserts on it.
- Redirect (branch_taken=1):
  - pcF <= {branch_target[DPW-1:2], 2'b00}.
  - Fetch queue cleared.
  - discard <= outstanding minus (1 if a non-discarded rvalid arrives this cycle, else 0), plus the old discard.
  - outstanding <= 0 for credit purposes; discarded slots are re-credited as they drain.
  - Redirect overrides stallD.
- IF/ID register, priority order:
  1. flushD or branch_taken -> instrD=NOP_INSTR, PCD=0, validD=0.
  2. stallD -> hold all; no pop.
  3. Queue non-empty -> pop head into instrD/PCD, validD=1.
  4. Otherwise -> bubble (NOP_INSTR, PCD=0, validD=0).
- Latency: best case, gnt in cycle N, rvalid in N+1, instrD valid after edge N+2 (pass-through from rvalid into IF/ID in the same cycle is not allowed).
- Reset mid-operation clears all state. In-flight responses after reset deassertion are the memory's responsibility: memory must be reset in the same domain.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined: perf_bubble_cnt increments (saturating at 2^32-1) every cycle the IF/ID register loads a bubble under rule 4 with !stallD && !flushD && !branch_taken.
- Undefined: counter logic absent, perf_bubble_cnt tied to 0.

Test Plan:
1. Reset release, memory with 1-cycle latency and gnt=1 -> imem_addr 0x0,0x4,0x8,...; validD=1 first at the 3rd edge after reset release with PCD=0x0; then one instruction per cycle.
2. stallD=1 for 3 cycles during streaming -> instrD/PCD held. Issue stops once outstanding+queue=2. On release, PCs continue in order with no gap or duplicate.
3. branch_taken=1, target=0x103 with 2 requests outstanding (latency 3) -> next imem_addr=0x100. Both stale responses dropped. First validD=1 has PCD=0x100.
4. flushD=1 single cycle with queue holding PC 0x20 -> bubble (validD=0, instrD=0x13). The next cycle pops PC 0x20, so flush does not clear the queue.
5. pcF=0xFFFF_FFFC granted -> next imem_addr=0x0000_0000.
6. With FETCH_PERF_EN, gnt held low 5 cycles after the queue drains -> perf_bubble_cnt increases by 5. Without FETCH_PERF_EN -> the counter reads 0.
